// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider for the EX stage.
//
// One restoring shift-subtract step is performed per clock (MSB first), so a
// non-zero divisor takes 32 BUSY cycles. A zero divisor skips the iterations
// and produces the architected all-ones quotient with the dividend as the
// remainder. Signed operation divides the magnitudes and then fixes the signs
// (the quotient truncates toward zero; the remainder takes the dividend sign).
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        DIV/DIVU present in EX (held while EX is stalled)
//   is_signed    1 = DIV, 0 = DIVU (sampled with start)
//   dividend     numerator
//   divisor      denominator
//   flush        annuls the in-flight division
//   ex_stall     EX stall from the pipeline controller (only used in DONE)
//   stall_req    combinational stall request to the pipeline controller
//   done         result valid (high exactly while in DONE)
//   quotient     result quotient
//   remainder    result remainder
//   div_by_zero  divisor was zero for the current result
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    input  logic        ex_stall,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [5:0]  cnt_r;
    logic [31:0] divisor_r;       // |divisor|
    logic [31:0] q_r;             // dividend bits shift out, quotient bits shift in
    logic [32:0] rem_r;           // partial remainder
    logic        signed_r;
    logic        dividend_neg_r;  // already qualified by is_signed
    logic        divisor_neg_r;   // already qualified by is_signed

    logic [33:0] diff_s;
    logic [32:0] rem_next_s;
    logic [31:0] q_next_s;

    // Two's-complement negate when requested; used for magnitudes and fixups.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        if (neg) begin
            cond_neg = 32'd0 - v;
        end else begin
            cond_neg = v;
        end
    endfunction

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        diff_s     = {rem_r, q_r[31]} - {2'b00, divisor_r};
        rem_next_s = {rem_r[31:0], q_r[31]};
        q_next_s   = {q_r[30:0], 1'b0};
        // A clear borrow bit means the subtraction fits, so keep it.
        if (!diff_s[33]) begin
            rem_next_s = diff_s[32:0];
            q_next_s   = {q_r[30:0], 1'b1};
        end else begin
            rem_next_s = {rem_r[31:0], q_r[31]};
            q_next_s   = {q_r[30:0], 1'b0};
        end
    end

    // Stall request: depends on state, start and flush only, never on ex_stall.
    always_comb begin
        stall_req = 1'b0;
        if (!rst_n) begin
            stall_req = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !flush) begin
                        stall_req = 1'b1;
                    end else begin
                        stall_req = 1'b0;
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        stall_req = 1'b1;
                    end else begin
                        stall_req = 1'b0;
                    end
                end
                DONE:    stall_req = 1'b0;
                default: stall_req = 1'b0;
            endcase
        end
    end

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            cnt_r          <= 6'd0;
            divisor_r      <= 32'd0;
            q_r            <= 32'd0;
            rem_r          <= 33'd0;
            signed_r       <= 1'b0;
            dividend_neg_r <= 1'b0;
            divisor_neg_r  <= 1'b0;
            done           <= 1'b0;
            quotient       <= 32'd0;
            remainder      <= 32'd0;
            div_by_zero    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (flush) begin
                        state_r <= IDLE;
                    end else if (start) begin
                        if (divisor == 32'd0) begin
                            state_r     <= DONE;
                            done        <= 1'b1;
                            quotient    <= 32'hFFFF_FFFF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state_r        <= BUSY;
                            q_r            <= cond_neg(dividend, is_signed & dividend[31]);
                            divisor_r      <= cond_neg(divisor, is_signed & divisor[31]);
                            signed_r       <= is_signed;
                            dividend_neg_r <= is_signed & dividend[31];
                            divisor_neg_r  <= is_signed & divisor[31];
                            rem_r          <= 33'd0;
                            cnt_r          <= 6'd0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state_r <= IDLE;
                        cnt_r   <= 6'd0;
                        rem_r   <= 33'd0;
                    end else begin
                        rem_r <= rem_next_s;
                        q_r   <= q_next_s;
                        if (cnt_r == 6'd31) begin
                            // Last step: results go straight from the step logic.
                            state_r     <= DONE;
                            cnt_r       <= 6'd0;
                            done        <= 1'b1;
                            quotient    <= cond_neg(q_next_s,
                                                    signed_r & (dividend_neg_r ^ divisor_neg_r));
                            remainder   <= cond_neg(rem_next_s[31:0], signed_r & dividend_neg_r);
                            div_by_zero <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + 6'd1;
                        end
                    end
                end
                DONE: begin
                    // Hold the result until EX actually advances.
                    if (flush || !ex_stall) begin
                        state_r <= IDLE;
                        done    <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    cnt_r   <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes the expected result from a
// plain-arithmetic reference model; a monitor pops and compares on every rising
// edge of done. The driver also checks the stall/done handshake timing.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        ex_stall;
    logic        stall_req;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    always #5 clk = ~clk;

    div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .flush       (flush),
        .ex_stall    (ex_stall),
        .stall_req   (stall_req),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    logic        prev_done = 1'b0;
    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;
    logic        last_dbz = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: language-level division with the architected corner cases.
    function automatic exp_t model(input logic sg, input logic [31:0] a,
                                   input logic [31:0] b, input int t);
        exp_t e;
        e.due = t + ((b == 32'd0) ? 1 : 33);
        e.dbz = 1'b0;
        if (b == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else if (sg) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: compare each presented result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done && !prev_done) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no result (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", quotient, mon_e.q);
                chk("remainder", remainder, mon_e.r);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
                chk("done_cycle", cyc, mon_e.due);
            end
        end
        prev_done <= done;
    end

    // Issue one division (called just after a posedge with the unit idle).
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input string tag);
        exp_t e;
        int   st_cnt;
        int   dn_cnt;
        int   guard;
        e = model(sg, a, b, cyc);
        sb.push_back(e);
        start = 1'b1; is_signed = sg; dividend = a; divisor = b;
        st_cnt = 0;
        guard  = 0;
        @(negedge clk);
        while (!done && guard < 60) begin
            if (stall_req) st_cnt++;
            guard++;
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL %s timeout: got no done, expected done within 60 cycles", tag);
        end
        chk({tag, " stall_cycles"}, st_cnt, (b == 32'd0) ? 1 : 33);
        dn_cnt   = 0;
        ex_stall = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            if (done && !stall_req) dn_cnt++;
            @(negedge clk);
        end
        if (done && !stall_req) dn_cnt++;
        ex_stall = 1'b0;
        chk({tag, " done_cycles"}, dn_cnt, hold + 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, " idle_after"}, {31'd0, done}, 32'd0);
        last_q = e.q; last_r = e.r; last_dbz = e.dbz;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = 32'd0;
        divisor = 32'd0; flush = 1'b0; ex_stall = 1'b0;
        #12;
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst stall_req", {31'd0, stall_req}, 32'd0);
        chk("rst quotient", quotient, 32'd0);
        chk("rst remainder", remainder, 32'd0);
        chk("rst div_by_zero", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_div(1'b0, 32'd100, 32'd7, 0, "u100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "s_m7_2");
        run_div(1'b1, 32'd5, 32'd0, 0, "s5_0");
        run_div(1'b0, 32'd5, 32'd0, 1, "u5_0");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s_ovf");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "u_max_1");
        run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "u_max_max");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "s7_m2");

        // Flush ten cycles into a division: nothing is produced, results hold.
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush stall_req", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush no_done", {31'd0, done}, 32'd0);
        end
        chk("flush quotient_kept", quotient, last_q);
        chk("flush remainder_kept", remainder, last_r);
        chk("flush dbz_kept", {31'd0, div_by_zero}, {31'd0, last_dbz});
        @(posedge clk);
        #1;
        run_div(1'b0, 32'd9, 32'd3, 0, "u9_3");
        run_div(1'b0, 32'd1000, 32'd33, 3, "hold3");

        // Asynchronous reset in the middle of a division.
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst done", {31'd0, done}, 32'd0);
        chk("midrst stall_req", {31'd0, stall_req}, 32'd0);
        chk("midrst quotient", quotient, 32'd0);
        chk("midrst remainder", remainder, 32'd0);
        chk("midrst div_by_zero", {31'd0, div_by_zero}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, "s_m100_7");

        for (int i = 0; i < 40; i++) begin
            rs = 1'(($urandom() & 32'd1));
            ra = $urandom();
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom() >> $urandom_range(0, 31);
            endcase
            if (rb == 32'd0 && $urandom_range(0, 3) != 0) rb = 32'd3;
            run_div(rs, ra, rb, int'($urandom_range(0, 2)), "rand");
        end

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
